// File: rtl/readout_discriminator.sv
// readout_discriminator
//
// Integrates I/Q ADC samples for a set of qubit readout lanes, then decides
// per lane whether the integrated energy |sum I| + |sum Q| strictly exceeds
// a threshold.
//
// Handshakes (both use valid/ready semantics): a transfer happens on a
// rising clock edge where the producer's valid and the consumer's ready are
// both 1. The producer holds its payload stable until the transfer. Here
// meas_start/meas_ready carry the request (meas_mask, meas_len, threshold),
// and result_valid/result_ready carry the decision vector.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   meas_start   request valid
//   meas_ready   request ready (1 exactly in IDLE)
//   meas_mask    lanes to measure, latched on accept
//   meas_len     valid samples to integrate, 0 means 256, latched on accept
//   threshold    unsigned energy threshold, latched on accept
//   adc_valid    adc_i/adc_q carry a sample this cycle
//   adc_i, adc_q packed signed samples, lane k at [k*SAMPLE_BITS +: SAMPLE_BITS]
//   result       per-lane decision, held until the next DISCRIMINATE
//   result_valid result valid (1 throughout REPORT)
//   result_ready consumer accepts result
//   fsm_state    current FSM state, for observation only
module readout_discriminator #(
    parameter int  NUM_QUBITS  = 8,
    parameter int  SAMPLE_BITS = 16,
    localparam int ACC_BITS    = SAMPLE_BITS + 9,
    localparam int THR_BITS    = ACC_BITS + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              meas_start,
    output logic                              meas_ready,
    input  logic [NUM_QUBITS-1:0]             meas_mask,
    input  logic [7:0]                        meas_len,
    input  logic [THR_BITS-1:0]               threshold,
    input  logic                              adc_valid,
    input  logic [NUM_QUBITS*SAMPLE_BITS-1:0] adc_i,
    input  logic [NUM_QUBITS*SAMPLE_BITS-1:0] adc_q,
    output logic [NUM_QUBITS-1:0]             result,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [1:0]                        fsm_state
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        INTEGRATE    = 2'd1,
        DISCRIMINATE = 2'd2,
        REPORT       = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_QUBITS-1:0] mask_q;
    logic [7:0]            len_q;
    logic [THR_BITS-1:0]   thr_q;
    logic [8:0]            count;
    logic [8:0]            target;
    logic                  accept;
    logic                  last_sample;

    // Accumulators are kept as plain two's-complement vectors; 256 samples of
    // a full-scale SAMPLE_BITS value need at most SAMPLE_BITS+9 bits.
    logic [ACC_BITS-1:0]   acc_i   [NUM_QUBITS];
    logic [ACC_BITS-1:0]   acc_q   [NUM_QUBITS];
    logic [ACC_BITS-1:0]   inc_i   [NUM_QUBITS];
    logic [ACC_BITS-1:0]   inc_q   [NUM_QUBITS];
    logic [NUM_QUBITS-1:0] decision;

    assign fsm_state   = state;
    assign accept      = meas_start & meas_ready;
    assign target      = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
    // count never exceeds 255 before the final sample, so count+1 fits 9 bits.
    assign last_sample = ((count + 9'd1) == target);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        meas_ready   = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                meas_ready = 1'b1;
                if (meas_start) begin
                    state_next = INTEGRATE;
                end
            end
            INTEGRATE: begin
                if (adc_valid && last_sample) begin
                    state_next = DISCRIMINATE;
                end
            end
            DISCRIMINATE: begin
                state_next = REPORT;
            end
            REPORT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane sign extension and energy / decision
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_QUBITS; k++) begin : g_lane
        logic [SAMPLE_BITS-1:0] s_i;
        logic [SAMPLE_BITS-1:0] s_q;
        logic [THR_BITS-1:0]    ext_i;
        logic [THR_BITS-1:0]    ext_q;
        logic [THR_BITS-1:0]    mag_i;
        logic [THR_BITS-1:0]    mag_q;
        logic [THR_BITS-1:0]    energy;

        assign s_i      = adc_i[k*SAMPLE_BITS +: SAMPLE_BITS];
        assign s_q      = adc_q[k*SAMPLE_BITS +: SAMPLE_BITS];
        assign inc_i[k] = {{(ACC_BITS-SAMPLE_BITS){s_i[SAMPLE_BITS-1]}}, s_i};
        assign inc_q[k] = {{(ACC_BITS-SAMPLE_BITS){s_q[SAMPLE_BITS-1]}}, s_q};

        // Widen by one bit before negating so the most negative accumulator
        // value has a representable magnitude; the sum of two magnitudes is
        // at most 2^ACC_BITS, which still fits in THR_BITS.
        assign ext_i  = {acc_i[k][ACC_BITS-1], acc_i[k]};
        assign ext_q  = {acc_q[k][ACC_BITS-1], acc_q[k]};
        assign mag_i  = ext_i[THR_BITS-1] ? (~ext_i + THR_BITS'(1)) : ext_i;
        assign mag_q  = ext_q[THR_BITS-1] ? (~ext_q + THR_BITS'(1)) : ext_q;
        assign energy = mag_i + mag_q;

        assign decision[k] = mask_q[k] & (energy > thr_q);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            len_q  <= '0;
            thr_q  <= '0;
            count  <= '0;
            result <= '0;
            for (int k = 0; k < NUM_QUBITS; k++) begin
                acc_i[k] <= '0;
                acc_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                mask_q <= meas_mask;
                len_q  <= meas_len;
                thr_q  <= threshold;
                count  <= '0;
                for (int k = 0; k < NUM_QUBITS; k++) begin
                    acc_i[k] <= '0;
                    acc_q[k] <= '0;
                end
            end else if (state == INTEGRATE && adc_valid) begin
                count <= count + 9'd1;
                for (int k = 0; k < NUM_QUBITS; k++) begin
                    if (mask_q[k]) begin
                        acc_i[k] <= acc_i[k] + inc_i[k];
                        acc_q[k] <= acc_q[k] + inc_q[k];
                    end
                end
            end

            // result only changes here, so it stays stable through REPORT
            // and keeps its value after the handshake.
            if (state == DISCRIMINATE) begin
                result <= decision;
            end
        end
    end

endmodule

// File: doc/readout_discriminator.md
READOUT_DISCRIMINATOR -- requirements
Module: readout_discriminator

Interface
REQ-001 The block SHALL have parameter NUM_QUBITS, default 8, meaning the number of readout lanes.
REQ-002 The block SHALL have parameter SAMPLE_BITS, default 16, meaning the signed ADC sample width.
REQ-003 The block SHALL use ACC_BITS = SAMPLE_BITS+9 as the signed accumulator width, and SHALL use THR_BITS = ACC_BITS+1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port meas_start, input, 1 bit: measurement request.
REQ-007 The block SHALL have port meas_ready, output, 1 bit: the block can accept a request.
REQ-008 The block SHALL have port meas_mask, input, NUM_QUBITS bits: lanes to measure, sampled on accept.
REQ-009 The block SHALL have port meas_len, input, 8 bits: integration length in valid samples (0 = 256), sampled on accept.
REQ-010 The block SHALL have port threshold, input, THR_BITS bits, unsigned: energy threshold, sampled on accept.
REQ-011 The block SHALL have port adc_valid, input, 1 bit: adc_i/adc_q carry a sample this cycle.
REQ-012 The block SHALL have ports adc_i and adc_q, input, NUM_QUBITS*SAMPLE_BITS bits each: signed samples, lane k at [k*SAMPLE_BITS +: SAMPLE_BITS].
REQ-013 The block SHALL have port result, output, NUM_QUBITS bits: per-lane state decision.
REQ-014 The block SHALL have port result_valid, output, 1 bit: result is valid.
REQ-015 The block SHALL have port result_ready, input, 1 bit: the consumer accepts result.

Function
REQ-016 The FSM SHALL have the states IDLE, INTEGRATE, DISCRIMINATE and REPORT.
REQ-017 meas_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 A request SHALL be accepted when meas_start=1 and meas_ready=1, with these effects:
- mask, length and threshold are latched;
- all accumulators and the sample counter are cleared;
- the next state is INTEGRATE.
REQ-019 meas_start SHALL be ignored in every state except IDLE.
REQ-020 In INTEGRATE, each cycle with adc_valid=1, every masked lane SHALL add its sign-extended adc_i to acc_i[k] and its adc_q to acc_q[k], and the sample counter SHALL increment.
REQ-021 Cycles with adc_valid=0 SHALL leave the accumulators and the counter unchanged.
REQ-022 Unmasked lane accumulators SHALL remain zero.
REQ-023 When the N-th valid sample (N = meas_len, or 256 if meas_len=0) is accumulated in cycle T, the state SHALL be DISCRIMINATE in T+1 and REPORT in T+2.
REQ-024 In DISCRIMINATE, the energy SHALL be computed as E[k] = |acc_i[k]| + |acc_q[k]|, unsigned, THR_BITS wide, with no overflow for any input.
REQ-025 The decision SHALL be result[k] = mask[k] AND (E[k] > threshold), with strictly-greater comparison; this value is registered into result.
REQ-026 result_valid SHALL be 1 throughout REPORT, starting in T+2.
REQ-027 While result_valid=1 and result_ready=0, result SHALL be held stable.
REQ-028 On a handshake (result_valid=1 and result_ready=1) in REPORT, the next state SHALL be IDLE, result_valid SHALL be 0 in the next cycle, and result SHALL keep its last value.
REQ-029 The minimum request-to-result latency SHALL be N+2 cycles after the accept cycle, with adc_valid held at 1.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL:
- set the state to IDLE;
- set result_valid=0 and result=0;
- clear the accumulators, the counter and the latched mask/length/threshold.
REQ-031 After reset, meas_ready SHALL be 1.
REQ-032 A reset during INTEGRATE, DISCRIMINATE or REPORT SHALL abandon the measurement with no partial result emitted.

Verification
REQ-033 Reset: hold rst=1 for 2 cycles -> meas_ready=1, result_valid=0, result=0x00.
REQ-034 Basic measurement:
- stimulus: mask=0x01, len=4, threshold=1000; lane0 I=+300, Q=-100; adc_valid=1 continuously;
- response: result=0x01, with result_valid rising 6 cycles after the accept.
REQ-035 Equality boundary: lane0 I=+250, Q=0, len=4, threshold=1000 -> E=1000 and result=0x00.
REQ-036 Full length with gaps:
- stimulus: len=0, mask=0xFF, threshold=0; all lanes I=-32768, Q=+32767; adc_valid toggling every cycle;
- response: exactly 256 samples are accumulated, there is no overflow, and result=0xFF.
REQ-037 Mask and backpressure:
- stimulus: mask=0x02 with every lane at I=+32767; result_ready held at 0 for 10 cycles; meas_start=1 during REPORT;
- response: result=0x02 stays stable, the start is ignored, and meas_ready rises one cycle after the handshake.
REQ-038 Mid-operation reset:
- stimulus: rst pulsed after 2 of 4 samples, then a new request with len=1, I=+5, threshold=4;
- response: result=lane bit set only, proving the accumulators restarted from zero.
